// File: rtl/win_check_sequencer_if.sv
// -----------------------------------------------------------------------------
// win_check_sequencer_if
//   Bundles the game-FSM handshake and the board read port of the win check
//   sequencer.
//
//   Game FSM side : start, clear, last_row, last_col, player  (to sequencer)
//                   busy, done, win_flag, winner_id, draw_flag (from sequencer)
//   Board side    : rd_en, rd_row, rd_col                      (from sequencer)
//                   rd_data                                    (to sequencer)
//
//   Modports: slave  = the sequencer itself
//             master = the game FSM / board pair driving it
// -----------------------------------------------------------------------------
interface win_check_sequencer_if #(
  parameter int ROWS = 6,
  parameter int COLS = 7,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
);
  logic          start;
  logic          clear;
  logic [RW-1:0] last_row;
  logic [CW-1:0] last_col;
  logic [1:0]    player;
  logic          busy;
  logic          done;
  logic          win_flag;
  logic [1:0]    winner_id;
  logic          draw_flag;
  logic          rd_en;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [1:0]    rd_data;

  modport slave (
    input  start, clear, last_row, last_col, player, rd_data,
    output busy, done, win_flag, winner_id, draw_flag, rd_en, rd_row, rd_col
  );

  modport master (
    output start, clear, last_row, last_col, player, rd_data,
    input  busy, done, win_flag, winner_id, draw_flag, rd_en, rd_row, rd_col
  );
endinterface

// File: rtl/win_check_sequencer.sv
// -----------------------------------------------------------------------------
// win_check_sequencer
//   After each inserted piece, walks the four lines (horizontal, vertical,
//   diagonal up-right, diagonal down-right) through the last piece, one board
//   cell per read, and reports win / winner / draw back to the game FSM.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous reset, active low
//     bus    win_check_sequencer_if.slave
//              start/last_row/last_col/player  request, captured when idle
//              clear                           sync clear of move counter + results
//              rd_en/rd_row/rd_col/rd_data     board read port, 1-cycle read latency
//              busy/done                       scan status, done is a 1-cycle pulse
//              win_flag/winner_id/draw_flag    registered results
//
//   Each line is scanned from the last piece outwards, first on the + side then
//   on the - side, accumulating a single contiguous count per line. A line that
//   reaches WIN_LEN ends the whole scan early.
// -----------------------------------------------------------------------------
module win_check_sequencer #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  win_check_sequencer_if.slave bus
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int KW = $clog2(WIN_LEN);          // step k = 1 .. WIN_LEN-1
  localparam int NW = $clog2(WIN_LEN + 1);      // line count = 1 .. WIN_LEN
  localparam int MW = $clog2(ROWS * COLS + 1);  // move counter = 0 .. ROWS*COLS

  localparam logic [KW-1:0] K_LAST = KW'(WIN_LEN - 1);
  localparam logic [NW-1:0] N_WIN  = NW'(WIN_LEN);
  localparam logic [MW-1:0] CELLS  = MW'(ROWS * COLS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CMP,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    dir_q, dir_d;       // 0 H, 1 V, 2 diag up-right, 3 diag down-right
  logic          side_q, side_d;     // 0 = + side, 1 = - side
  logic [KW-1:0] k_q, k_d;
  logic [NW-1:0] count_q, count_d;
  logic [RW-1:0] row0_q, row0_d;
  logic [CW-1:0] col0_q, col0_d;
  logic [1:0]    player_q, player_d;
  logic [MW-1:0] moves_q, moves_d;
  logic          win_q, win_d;
  logic [1:0]    winner_q, winner_d;
  logic          draw_q, draw_d;
  logic [RW-1:0] rd_row_q, rd_row_d;
  logic [CW-1:0] rd_col_q, rd_col_d;

  // ---------------------------------------------------------------------------
  // Coordinate of the cell under test: last +/- k*d. One extra sign bit lets
  // both edges (below 0 and beyond the board) be seen as out of range.
  // ---------------------------------------------------------------------------
  logic signed [1:0]  dr, dc;
  logic signed [RW:0] row_s, k_row;
  logic signed [CW:0] col_s, k_col;
  logic               in_bounds;

  always_comb begin
    unique case (dir_q)
      2'd0:    begin dr = 2'sd0;  dc = 2'sd1; end
      2'd1:    begin dr = 2'sd1;  dc = 2'sd0; end
      2'd2:    begin dr = 2'sd1;  dc = 2'sd1; end
      default: begin dr = -2'sd1; dc = 2'sd1; end
    endcase

    k_row = $signed((RW+1)'(k_q));
    k_col = $signed((CW+1)'(k_q));
    row_s = $signed({1'b0, row0_q});
    col_s = $signed({1'b0, col0_q});

    // The - side walks the same line with the direction vector negated.
    if (dr != 2'sd0) row_s = ((dr == 2'sd1) != side_q) ? row_s + k_row : row_s - k_row;
    if (dc != 2'sd0) col_s = ((dc == 2'sd1) != side_q) ? col_s + k_col : col_s - k_col;

    // Negative values reinterpreted as unsigned are >= 2**RW >= ROWS.
    in_bounds = ($unsigned(row_s) < (RW+1)'(ROWS)) && ($unsigned(col_s) < (CW+1)'(COLS));
  end

  // ---------------------------------------------------------------------------
  // Read port: address is only driven onto the bus while reading, otherwise the
  // last address issued is held.
  // ---------------------------------------------------------------------------
  logic rd_en;

  assign rd_en      = (state_q == S_ISSUE) && in_bounds;
  assign rd_row_d   = rd_en ? row_s[RW-1:0] : rd_row_q;
  assign rd_col_d   = rd_en ? col_s[CW-1:0] : rd_col_q;

  assign bus.rd_en     = rd_en;
  assign bus.rd_row    = rd_row_d;
  assign bus.rd_col    = rd_col_d;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.win_flag  = win_q;
  assign bus.winner_id = winner_q;
  assign bus.draw_flag = draw_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic          player_valid;
  logic          side_end;
  logic [NW-1:0] count_inc;

  assign player_valid = (bus.player == 2'b01) || (bus.player == 2'b10);
  assign count_inc    = count_q + NW'(1);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    dir_d    = dir_q;
    side_d   = side_q;
    k_d      = k_q;
    count_d  = count_q;
    row0_d   = row0_q;
    col0_d   = col0_q;
    player_d = player_q;
    moves_d  = moves_q;
    win_d    = win_q;
    winner_d = winner_q;
    draw_d   = draw_q;
    side_end = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          row0_d   = bus.last_row;
          col0_d   = bus.last_col;
          player_d = bus.player;
          win_d    = 1'b0;
          winner_d = 2'b00;
          draw_d   = 1'b0;
          dir_d    = 2'd0;
          side_d   = 1'b0;
          k_d      = KW'(1);
          count_d  = NW'(1);
          if (player_valid) begin
            state_d = S_ISSUE;
            // Saturate: a full board stays full until clear.
            if (moves_q != CELLS) moves_d = moves_q + MW'(1);
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_ISSUE: begin
        if (in_bounds) state_d  = S_CMP;
        else           side_end = 1'b1;
      end

      S_CMP: begin
        if (bus.rd_data == player_q) begin
          if (count_inc >= N_WIN) begin
            state_d  = S_DONE;
            win_d    = 1'b1;
            winner_d = player_q;
          end else begin
            count_d = count_inc;
            if (k_q == K_LAST) begin
              side_end = 1'b1;
            end else begin
              k_d     = k_q + KW'(1);
              state_d = S_ISSUE;
            end
          end
        end else begin
          side_end = 1'b1;
        end
      end

      default: begin  // S_DONE
        state_d = S_IDLE;
      end
    endcase

    // The - side continues the same line count; a new direction restarts it.
    if (side_end) begin
      k_d     = KW'(1);
      state_d = S_ISSUE;
      if (!side_q) begin
        side_d = 1'b1;
      end else if (dir_q == 2'd3) begin
        state_d = S_DONE;
        draw_d  = (moves_q == CELLS);
      end else begin
        dir_d   = dir_q + 2'd1;
        side_d  = 1'b0;
        count_d = NW'(1);
      end
    end

    if (bus.clear) begin
      state_d  = S_IDLE;
      moves_d  = '0;
      win_d    = 1'b0;
      winner_d = 2'b00;
      draw_d   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here so every flop samples the values that
  // were settled before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dir_q    <= 2'd0;
      side_q   <= 1'b0;
      k_q      <= '0;
      count_q  <= '0;
      row0_q   <= '0;
      col0_q   <= '0;
      player_q <= 2'b00;
      moves_q  <= '0;
      win_q    <= 1'b0;
      winner_q <= 2'b00;
      draw_q   <= 1'b0;
      rd_row_q <= '0;
      rd_col_q <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      side_q   <= side_d;
      k_q      <= k_d;
      count_q  <= count_d;
      row0_q   <= row0_d;
      col0_q   <= col0_d;
      player_q <= player_d;
      moves_q  <= moves_d;
      win_q    <= win_d;
      winner_q <= winner_d;
      draw_q   <= draw_d;
      rd_row_q <= rd_row_d;
      rd_col_q <= rd_col_d;
    end
  end

endmodule

// File: tb/tb_win_check_sequencer.sv
// -----------------------------------------------------------------------------
// tb_win_check_sequencer
//   Drives win_check_sequencer through directed game situations and random
//   boards. Expected results come from a line-counting reference model over a
//   board array held here; the same array answers the DUT's board reads.
// -----------------------------------------------------------------------------
module tb_win_check_sequencer;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int WIN_LEN = 4;
  localparam int RW      = $clog2(ROWS);
  localparam int CW      = $clog2(COLS);

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  win_check_sequencer_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  win_check_sequencer #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_vec = 0;
  int         n_bad = 0;
  int         moves = 0;
  logic [1:0] board [ROWS][COLS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Board memory: address sampled mid-cycle, data returned on the next edge.
  bit            pend_en;
  logic [RW-1:0] pend_row;
  logic [CW-1:0] pend_col;

  always @(negedge clk) begin
    pend_en  <= 1'b0;
    if (rst_n === 1'b1 && bus.rd_en === 1'b1) begin
      check("rd_addr_in_range", (int'(bus.rd_row) < ROWS) && (int'(bus.rd_col) < COLS), 1);
      pend_en  <= (int'(bus.rd_row) < ROWS) && (int'(bus.rd_col) < COLS);
      pend_row <= bus.rd_row;
      pend_col <= bus.rd_col;
    end
  end

  always @(posedge clk) begin
    if (pend_en) bus.rd_data <= board[pend_row][pend_col];
  end

  // Reference: for each line, count contiguous player cells outward on both
  // sides; stop at the first line reaching WIN_LEN. Also tallies board reads.
  function automatic void model(input int r0, input int c0, input logic [1:0] p,
                                output bit win, output int reads);
    int dr, dc, cnt, sg, r, c;
    win   = 1'b0;
    reads = 0;
    if (p != 2'b01 && p != 2'b10) return;
    for (int d = 0; d < 4 && !win; d++) begin
      case (d)
        0:       begin dr = 0;  dc = 1; end
        1:       begin dr = 1;  dc = 0; end
        2:       begin dr = 1;  dc = 1; end
        default: begin dr = -1; dc = 1; end
      endcase
      cnt = 1;
      for (int s = 0; s < 2 && !win; s++) begin
        sg = (s == 0) ? 1 : -1;
        for (int k = 1; k < WIN_LEN; k++) begin
          r = r0 + sg * k * dr;
          c = c0 + sg * k * dc;
          if (r < 0 || r >= ROWS || c < 0 || c >= COLS) break;
          reads++;
          if (board[r][c] != p) break;
          cnt++;
          if (cnt >= WIN_LEN) begin
            win = 1'b1;
            break;
          end
        end
      end
    end
  endfunction

  task automatic clear_board();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        board[r][c] = 2'b00;
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    moves = 0;
  endtask

  // One complete request; inject_at > 0 pulses a second start while busy.
  task automatic run_scan(input int r, input int c, input logic [1:0] p,
                          input int inject_at, input string tag);
    bit ew, valid, got;
    int er, reads, lat;
    valid = (p == 2'b01) || (p == 2'b10);
    model(r, c, p, ew, er);
    if (valid && moves < ROWS * COLS) moves++;

    @(negedge clk);
    bus.start    = 1'b1;
    bus.last_row = RW'(r);
    bus.last_col = CW'(c);
    bus.player   = p;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.last_row = RW'($urandom);
    bus.last_col = CW'($urandom);
    bus.player   = 2'($urandom);
    check({tag, ".busy"}, bus.busy, 1);

    reads = 0;
    got   = 1'b0;
    lat   = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (bus.rd_en) reads++;
      if (bus.done) begin
        got = 1'b1;
        lat = cyc;
        break;
      end
      bus.start = (cyc == inject_at);
      @(negedge clk);
    end
    bus.start = 1'b0;

    check({tag, ".done_seen"}, got, 1);
    check({tag, ".latency_le_50"}, (lat <= 50), 1);
    check({tag, ".win_flag"}, bus.win_flag, ew);
    check({tag, ".winner_id"}, bus.winner_id, ew ? p : 2'b00);
    check({tag, ".draw_flag"}, bus.draw_flag, valid && !ew && (moves == ROWS * COLS));
    check({tag, ".reads"}, reads, er);
    @(negedge clk);
    check({tag, ".idle_after"}, {bus.busy, bus.done}, 0);
  endtask

  initial begin
    bit         got;
    int         dens;
    logic [1:0] p;

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.clear    = 1'b0;
    bus.last_row = '0;
    bus.last_col = '0;
    bus.player   = 2'b00;
    clear_board();
    repeat (3) @(negedge clk);
    check("reset.outputs",
          {bus.rd_en, bus.busy, bus.done, bus.win_flag, bus.winner_id, bus.draw_flag,
           bus.rd_row, bus.rd_col}, 0);
    rst_n = 1'b1;

    // Horizontal win completed at the right end of a bottom-row run.
    board[0][0] = 2'b01; board[0][1] = 2'b01; board[0][2] = 2'b01; board[0][3] = 2'b01;
    run_scan(0, 3, 2'b01, 0, "h_win");

    // Reset while idle drops the held results.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_idle.flags", {bus.win_flag, bus.winner_id, bus.draw_flag, bus.busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    moves = 0;

    // Vertical three only: full four-direction scan without a win.
    clear_board();
    board[0][4] = 2'b10; board[1][4] = 2'b10; board[2][4] = 2'b10;
    run_scan(2, 4, 2'b10, 0, "v_three");

    // Diagonal win made of both sides around the last piece.
    clear_board();
    board[0][0] = 2'b10; board[1][1] = 2'b10; board[2][2] = 2'b10; board[3][3] = 2'b10;
    run_scan(1, 1, 2'b10, 0, "diag_split");

    // Corner piece: many out-of-range neighbours that must not be read.
    clear_board();
    run_scan(0, 0, 2'b01, 0, "corner");
    run_scan(ROWS-1, COLS-1, 2'b10, 0, "far_corner");

    // Invalid player codes: no reads, immediate done, results all zero.
    run_scan(2, 2, 2'b00, 0, "player_00");
    run_scan(3, 3, 2'b11, 0, "player_11");

    // Reset in the middle of a scan.
    @(negedge clk);
    bus.start = 1'b1; bus.last_row = 3'd3; bus.last_col = 3'd3; bus.player = 2'b01;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_mid.busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid.outputs",
          {bus.rd_en, bus.busy, bus.done, bus.win_flag, bus.winner_id, bus.draw_flag}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    moves = 0;
    run_scan(3, 3, 2'b01, 0, "after_rst");

    // Clear in the middle of a scan aborts it without done.
    @(negedge clk);
    bus.start = 1'b1; bus.last_row = 3'd2; bus.last_col = 3'd3; bus.player = 2'b10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("clr_mid.busy_before", bus.busy, 1);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    moves = 0;
    check("clr_mid.busy_after", bus.busy, 0);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.done) got = 1'b1;
      @(negedge clk);
    end
    check("clr_mid.no_done", got, 0);

    // Fill the move counter: a dropped start must not count, draw on the 42nd,
    // kept on the 43rd, removed by clear.
    clear_board();
    do_clear();
    run_scan(2, 3, 2'b01, 5, "busy_drop");
    for (int i = 2; i <= ROWS * COLS + 1; i++)
      run_scan($urandom_range(ROWS-1, 0), $urandom_range(COLS-1, 0), 2'b01, 0,
               $sformatf("fill%0d", i));
    check("full.draw_before_clear", bus.draw_flag, 1);
    do_clear();
    check("full.draw_after_clear", bus.draw_flag, 0);

    // Random boards, players and occasional clears.
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(19, 0) == 0) do_clear();
      dens = $urandom_range(3, 1);
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          board[r][c] = ($urandom_range(3, 0) < dens)
                        ? (($urandom_range(1, 0) == 1) ? 2'b01 : 2'b10) : 2'b00;
      if ($urandom_range(9, 0) == 0) p = ($urandom_range(1, 0) == 1) ? 2'b11 : 2'b00;
      else                           p = ($urandom_range(1, 0) == 1) ? 2'b01 : 2'b10;
      run_scan($urandom_range(ROWS-1, 0), $urandom_range(COLS-1, 0), p, 0,
               $sformatf("rand%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
